imem_loader: RTL and testbench

- Upstream feeder for the 5-stage pipeline top level.
- Accepts a byte stream over a valid/ready handshake and writes it into the 256-byte instruction memory array that drives the pipeline's `instruction_mem` input.
- Zero-fills the unused tail of that memory.
- Holds the processor in reset until a complete, well-formed image is loaded, then releases it.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams an instruction image into the pipeline's byte-wide
// instruction memory and holds the processor in reset until a complete,
// word-aligned image is present.
//
// Ports:
//   clk             - single clock, all state on its rising edge
//   reset           - synchronous, active-low
//   load_start      - one-cycle request to begin a new load (IDLE/RUN only)
//   in_valid/in_ready/in_data/in_last - byte stream handshake, big-endian words
//   instruction_mem - registered memory image feeding the pipeline
//   cpu_hold        - 1 holds the processor in reset
//   busy            - loading, draining an oversized image, or zero-filling
//   done            - image loaded, processor running
//   error           - last load failed; sticky until next load_start/reset
//   byte_count      - bytes accepted in the current or last load
module imem_loader #(
  parameter int MEM_BYTES  = 256,
  parameter int WORD_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic [7:0]                 instruction_mem [MEM_BYTES-1:0],
  output logic                       cpu_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(MEM_BYTES):0] byte_count
);

  localparam int PTR_W   = $clog2(MEM_BYTES);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ALIGN_W = $clog2(WORD_BYTES);

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(MEM_BYTES);
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(MEM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CLEAR, RUN} state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count_inc;
  logic               xfer;
  logic               misaligned;

  always_comb begin
    in_ready   = (state == LOAD) || (state == DRAIN);
    xfer       = in_valid && in_ready;
    count_inc  = byte_count + CNT_W'(1);
    misaligned = count_inc[ALIGN_W-1:0] != '0;

    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        if (xfer) begin
          if (in_last) begin
            if (misaligned)              state_next = IDLE;
            else if (count_inc == FULL)  state_next = RUN;
            else                         state_next = CLEAR;
          end else if (count_inc == FULL) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && in_last) state_next = IDLE;
      end
      CLEAR: begin
        if (wr_ptr == LAST_ADDR) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      byte_count <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      for (int unsigned i = 0; i < MEM_BYTES; i++) begin
        instruction_mem[PTR_W'(i)] <= '0;
      end
    end else begin
      state    <= state_next;
      // Status flags are registered from the next state so they line up
      // with the state register rather than lagging it by a cycle.
      cpu_hold <= (state_next != RUN);
      done     <= (state_next == RUN);
      busy     <= (state_next == LOAD) || (state_next == DRAIN) ||
                  (state_next == CLEAR);

      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            wr_ptr     <= '0;
            byte_count <= '0;
            error      <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            instruction_mem[wr_ptr] <= in_data;
            wr_ptr                  <= wr_ptr + PTR_W'(1);
            byte_count              <= count_inc;
            // A terminating byte fails on alignment; a non-terminating byte
            // that fills the memory means the image is too long.
            if (in_last ? misaligned : (count_inc == FULL)) error <= 1'b1;
          end
        end
        CLEAR: begin
          // Terminal write at LAST_ADDR wraps wr_ptr to 0; that value is unused.
          instruction_mem[wr_ptr] <= '0;
          wr_ptr                  <= wr_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader. Stimulus pushes
// the expected end-of-load status and memory image; a monitor pops and
// compares whenever a load finishes (busy falls) or reset is released.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] imem [255:0];
  logic       cpu_hold, busy, done, error;
  logic [8:0] byte_count;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(256), .WORD_BYTES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_start      (load_start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .instruction_mem (imem),
    .cpu_hold        (cpu_hold),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .byte_count      (byte_count)
  );

  typedef struct packed {
    logic       done;
    logic       error;
    logic       cpu_hold;
    logic       in_ready;
    logic [8:0] count;
    int         latency;  // edges from last accepted byte to busy falling, -1 = don't care
    int         err_at;   // accepted bytes in this load when error rose, -1 = don't care
  } st_t;

  st_t           sq[$];
  logic [2047:0] iq[$];
  logic [7:0]    eimg [256];
  logic [7:0]    prog [8];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_event(input int lat, input int eat);
    st_t           s;
    logic [2047:0] v;
    int            nbad;
    int            first;
    if (sq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: output event at %0t with no expected entry", $time);
      return;
    end
    s = sq.pop_front();
    v = iq.pop_front();
    chk("done",       32'(done),       32'(s.done));
    chk("error",      32'(error),      32'(s.error));
    chk("cpu_hold",   32'(cpu_hold),   32'(s.cpu_hold));
    chk("in_ready",   32'(in_ready),   32'(s.in_ready));
    chk("byte_count", 32'(byte_count), 32'(s.count));
    if (s.latency >= 0) chk("latency", 32'(lat), 32'(s.latency));
    if (s.err_at >= 0)  chk("err_at",  32'(eat), 32'(s.err_at));
    nbad  = 0;
    first = 0;
    for (int a = 0; a < 256; a++) begin
      if (imem[a] !== v[8*a +: 8]) begin
        if (nbad == 0) first = a;
        nbad++;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL mem: %0d bytes differ, first at %0d got %0h expected %0h",
               nbad, first, imem[first], v[8*first +: 8]);
    end
  endtask

  // Monitor: all sampling on the falling edge, away from the active edge.
  initial begin
    int edges  = 0;
    int last_x = 0;
    int xcnt   = 0;
    int err_at = -1;
    bit pend   = 1'b0;
    bit pbusy  = 1'b0;
    bit perr   = 1'b0;
    bit prst   = 1'b0;
    forever begin
      @(negedge clk);
      edges++;
      if (pend) begin
        xcnt++;
        last_x = edges;
      end
      if (busy && !pbusy) begin
        xcnt   = 0;
        err_at = -1;
      end
      if (error && !perr && err_at < 0) err_at = xcnt;
      if (reset && !prst)                     check_event(edges - last_x, err_at);
      else if (reset && pbusy && !busy)       check_event(edges - last_x, err_at);
      pend  = in_valid && in_ready && reset;
      pbusy = busy;
      perr  = error;
      prst  = reset;
    end
  end

  task automatic push(input logic d, input logic e, input logic h, input logic r,
                      input int cnt, input int lat, input int eat);
    st_t           s;
    logic [2047:0] v;
    s.done     = d;
    s.error    = e;
    s.cpu_hold = h;
    s.in_ready = r;
    s.count    = 9'(cnt);
    s.latency  = lat;
    s.err_at   = eat;
    for (int a = 0; a < 256; a++) v[8*a +: 8] = eimg[a];
    sq.push_back(s);
    iq.push_back(v);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int gap);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready stayed %0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sq.size() != 0 && n < 4000) begin
      n++;
      @(posedge clk);
    end
    if (sq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL event_timeout: %0d expected events pending, required 0", sq.size());
      sq.delete();
      iq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

    // Reset state
    for (int a = 0; a < 256; a++) eimg[a] = 8'h00;
    push(1'b0, 1'b0, 1'b1, 1'b0, 0, -1, -1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_drain();

    // 8-byte image, then 248 zero-fill cycles before release
    for (int a = 0; a < 8; a++) eimg[a] = prog[a];
    push(1'b1, 1'b0, 1'b0, 1'b0, 8, 248, -1);
    start_load();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7, 0);
    wait_drain();

    // Same image with gaps; a load_start mid-load must be ignored
    push(1'b1, 1'b0, 1'b0, 1'b0, 8, 248, -1);
    start_load();
    for (int i = 0; i < 8; i++) begin
      send(prog[i], i == 7, 1);
      if (i == 3) start_load();
    end
    wait_drain();

    // 6-byte image: misaligned, tail keeps previous contents
    for (int i = 0; i < 6; i++) eimg[i] = 8'(8'hAA + i * 17);
    push(1'b0, 1'b1, 1'b1, 1'b0, 6, 0, 6);
    start_load();
    for (int i = 0; i < 6; i++) send(8'(8'hAA + i * 17), i == 5, 0);
    wait_drain();

    // 260-byte image: overflow after byte 256, remainder drained
    for (int i = 0; i < 256; i++) eimg[i] = 8'(i * 7 + 3);
    push(1'b0, 1'b1, 1'b1, 1'b0, 256, 0, 256);
    start_load();
    for (int i = 0; i < 260; i++) send(8'(i * 7 + 3), i == 259, 0);
    wait_drain();

    // Exactly 256 bytes: straight to RUN, no zero-fill
    for (int i = 0; i < 256; i++) eimg[i] = 8'(255 - i);
    push(1'b1, 1'b0, 1'b0, 1'b0, 256, 0, -1);
    start_load();
    for (int i = 0; i < 256; i++) send(8'(255 - i), i == 255, 0);
    wait_drain();

    // Reload from RUN, reset mid-load wipes everything
    for (int a = 0; a < 256; a++) eimg[a] = 8'h00;
    push(1'b0, 1'b0, 1'b1, 1'b0, 0, -1, -1);
    start_load();
    send(8'h11, 1'b0, 0);
    start_load();
    send(8'h22, 1'b0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_drain();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
